exec_addx_arb: RTL and testbench
================================

// Module: exec_addx_arb
// PURPOSE
//  Shares a single add/sub unit (exec_addx) among N_REQ requesters in the exec stage.
//  Round-robin arbitration feeds one registered response stage: result, flags and requester id.
//  One operation is accepted per cycle when the response stage can take it; results return after a fixed 1 cycle.
// PARAMETERS
//  N_REQ   4               number of requesters, 2..8
//  W_ID    $clog2(N_REQ)   width of the requester id
//  W_OPR   (params.v)      operand width, shared with exec_addx
//  W_FLAGS (params.v)      flag width: {overflow, sign, zero, carry}
// PORTS
//  clk_i         in   1              clock, rising edge
//  rst_i         in   1              asynchronous reset, active-high
//  req_valid_i   in   N_REQ          per-requester operation valid
//  req_ready_o   out  N_REQ          per-requester accept; one-hot or zero
//  req_opr0_i    in   N_REQ*W_OPR    operand 0; slice k = [k*W_OPR +: W_OPR]
//  req_opr1_i    in   N_REQ*W_OPR    operand 1; same slicing
//  req_minus_i   in   N_REQ          1 = opr0 - opr1, 0 = opr0 + opr1
//  rsp_valid_o   out  1              response stage holds a result
//  rsp_ready_i   in   1              consumer takes the response
//  rsp_id_o      out  W_ID           index of the requester that issued the result
//  rsp_result_o  out  W_OPR          exec_addx result_o, registered
//  rsp_flags_o   out  W_FLAGS        exec_addx flags_o, registered
// BEHAVIOUR
//  - Reset (async, rst_i=1): rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, rsp_flags_o=0, rr_ptr=0.
//    req_ready_o=0 while rst_i is high. An in-flight response is dropped.
//  - Stage states: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1).
//    can_accept = EMPTY | (FULL & rsp_ready_i).
//  - Grant: combinational. Scan req_valid_i starting at rr_ptr, wrap N_REQ-1 -> 0; first set bit wins.
//    req_ready_o[g] = can_accept & req_valid_i[g]; all other bits are 0.
//  - Transfer on a requester when req_valid_i[g] & req_ready_o[g].
//    On transfer: latch exec_addx(opr0[g], opr1[g], minus[g]) into the stage, rsp_id_o<=g,
//    rsp_valid_o<=1, rr_ptr <= (g+1) mod N_REQ.
//  - Latency: exactly 1 cycle from transfer to rsp_valid_o.
//    Throughput: 1 op/cycle while rsp_ready_i=1 (simultaneous drain and fill in the same cycle).
//  - FULL & !rsp_ready_i: stall. All rsp_* outputs are held stable, req_ready_o=0, rr_ptr unchanged.
//  - FULL & rsp_ready_i & no request: rsp_valid_o<=0. The data registers are don't-care but are held.
//  - No request: rr_ptr unchanged. A requester may drop req_valid_i without transfer (no lock).
//  - Arithmetic: unchanged exec_addx semantics. minus uses two's complement of opr1.
//    carry = bit W_OPR of the sum. Overflow is signed.
//  - Fairness: each valid requester is granted within N_REQ transfers.
// CONFIGURATION
//  ADDX_ARB_LOCK_EN defined:
//  - Adds port req_lock_i (in, N_REQ).
//  - A transfer with req_lock_i[g]=1 sets lock_q=1 and lock_id_q=g, and rr_ptr is not advanced.
//  - While lock_q is set, only lock_id_q can be granted; other requesters see ready=0.
//  - Lock clears on a transfer from lock_id_q with req_lock_i=0.
//  - Lock also clears on any cycle where lock_id_q has req_valid_i=0 and can_accept=1.
//  - When the lock clears, rr_ptr <= lock_id_q+1.
//  - Reset clears lock_q and lock_id_q.
//  - Use: back-to-back multi-word add/sub sequences.
//  ADDX_ARB_LOCK_EN undefined:
//  - The port and the lock registers are absent; pure round-robin.
// TESTING (W_OPR=32, N_REQ=4)
//  1. Reset: rst_i pulsed mid-stall with rsp_valid_o=1 -> same cycle all rsp_* outputs 0, req_ready_o=0; rr_ptr=0 after.
//  2. Single op: req0 opr0=0x7FFFFFFF, opr1=1, minus=0 -> next cycle rsp_valid_o=1, id=0,
//     result=0x80000000, flags=4'b1100.
//  3. Subtract: req2 opr0=5, opr1=5, minus=1 -> result=0, flags=4'b0011, id=2.
//  4. Round-robin: all 4 valid continuously, rsp_ready_i=1 -> ids 0,1,2,3,0,... with one response per cycle.
//  5. Backpressure: rsp_ready_i=0 for 3 cycles with req1, req3 valid -> rsp_* stable and req_ready_o=0.
//     When rsp_ready_i rises -> drain and refill in the same cycle, with no bubble.
//  6. Lock (ADDX_ARB_LOCK_EN): req1 lock=1 for 3 ops while req0 is valid -> ids 1,1,1, then req1 unlocks -> id 0 next.

Source files
------------

// File: rtl/exec_addx_arb.sv
// Round-robin arbiter sharing one add/sub unit among N_REQ requesters; result registered, 1-cycle latency.
// Full stage with rsp_ready_i=0 stalls every requester; define ADDX_ARB_LOCK_EN for the requester lock.
module exec_addx_arb #(
  parameter int N_REQ   = 4,
  parameter int W_ID    = $clog2(N_REQ),
  parameter int W_OPR   = 32,
  parameter int W_FLAGS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*W_OPR-1:0] req_opr0_i,
  input  logic [N_REQ*W_OPR-1:0] req_opr1_i,
  input  logic [N_REQ-1:0]       req_minus_i,
`ifdef ADDX_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       req_lock_i,
`endif
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [W_ID-1:0]        rsp_id_o,
  output logic [W_OPR-1:0]       rsp_result_o,
  output logic [W_FLAGS-1:0]     rsp_flags_o
);

  typedef enum logic {ST_EMPTY, ST_FULL} stage_t;

  stage_t                     state_q;
  logic [W_ID-1:0]            rr_ptr_q;
  logic [N_REQ-1:0]           elig;
  logic                       can_accept;
  logic                       grant_vld;
  logic [W_ID-1:0]            grant_id;
  logic [W_ID:0]              idx;
  logic                       xfer;
  logic [W_FLAGS+W_OPR-1:0]   addx_out;

  // Flags are {overflow, sign, zero, carry}; subtraction is opr0 + ~opr1 + 1.
  function automatic logic [W_FLAGS+W_OPR-1:0] addx(input logic [W_OPR-1:0] a,
                                                    input logic [W_OPR-1:0] b,
                                                    input logic             minus);
    logic [W_OPR-1:0] b_eff;
    logic [W_OPR:0]   sum;
    logic             ovf;
    b_eff = minus ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{W_OPR{1'b0}}, minus};
    ovf   = (a[W_OPR-1] == b_eff[W_OPR-1]) && (sum[W_OPR-1] != a[W_OPR-1]);
    return {W_FLAGS'({ovf, sum[W_OPR-1], ~|sum[W_OPR-1:0], sum[W_OPR]}), sum[W_OPR-1:0]};
  endfunction

  function automatic logic [W_ID-1:0] inc_id(input logic [W_ID-1:0] id);
    return (id == W_ID'(N_REQ-1)) ? '0 : id + 1'b1;
  endfunction

  assign rsp_valid_o = (state_q == ST_FULL);
  assign can_accept  = (state_q == ST_EMPTY) || rsp_ready_i;

`ifdef ADDX_ARB_LOCK_EN
  logic            lock_q;
  logic [W_ID-1:0] lock_id_q;
  logic [N_REQ-1:0] lock_mask;

  always_comb begin
    lock_mask = '1;
    if (lock_q) begin
      lock_mask            = '0;
      lock_mask[lock_id_q] = 1'b1;
    end
  end
  assign elig = req_valid_i & lock_mask;
`else
  assign elig = req_valid_i;
`endif

  // Scan from rr_ptr_q upward with wrap; the first eligible requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_q} + (W_ID+1)'(i);
      if (idx >= (W_ID+1)'(N_REQ)) idx = idx - (W_ID+1)'(N_REQ);
      if (!grant_vld && elig[idx[W_ID-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[W_ID-1:0];
      end
    end
  end

  assign xfer = grant_vld && can_accept && !rst_i;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[grant_id] = 1'b1;
  end

  assign addx_out = addx(req_opr0_i[grant_id*W_OPR +: W_OPR],
                         req_opr1_i[grant_id*W_OPR +: W_OPR],
                         req_minus_i[grant_id]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_EMPTY;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_flags_o  <= '0;
      rr_ptr_q     <= '0;
`ifdef ADDX_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else if (xfer) begin
      state_q                     <= ST_FULL;
      rsp_id_o                    <= grant_id;
      {rsp_flags_o, rsp_result_o} <= addx_out;
`ifdef ADDX_ARB_LOCK_EN
      // A locking transfer keeps the pointer so the owner stays first in line.
      if (req_lock_i[grant_id]) begin
        lock_q    <= 1'b1;
        lock_id_q <= grant_id;
      end else begin
        lock_q   <= 1'b0;
        rr_ptr_q <= inc_id(grant_id);
      end
`else
      rr_ptr_q <= inc_id(grant_id);
`endif
    end else begin
      if (can_accept) state_q <= ST_EMPTY;
`ifdef ADDX_ARB_LOCK_EN
      if (lock_q && can_accept && !req_valid_i[lock_id_q]) begin
        lock_q   <= 1'b0;
        rr_ptr_q <= inc_id(lock_id_q);
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_addx_arb.sv
// Randomized self-checking bench for exec_addx_arb against a cycle-level behavioural model.
module tb_exec_addx_arb;
  localparam int N_REQ = 4, W_ID = 2, W_OPR = 32, W_FLAGS = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid = '0, req_ready, req_minus = '0;
  logic [N_REQ*W_OPR-1:0] req_opr0 = '0, req_opr1 = '0;
  logic                   rsp_valid, rsp_ready = 1'b0;
  logic [W_ID-1:0]        rsp_id;
  logic [W_OPR-1:0]       rsp_result;
  logic [W_FLAGS-1:0]     rsp_flags;
`ifdef ADDX_ARB_LOCK_EN
  logic [N_REQ-1:0]       req_lock = '0;
`endif

  int checks = 0, passes = 0;

  // Reference model state
  int          m_ptr = 0;
  bit          m_vld = 0;
  int          m_id = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_flags = '0;
  bit          m_lock = 0;
  int          m_lock_id = 0;

  always #5 clk = ~clk;

  exec_addx_arb #(.N_REQ(N_REQ), .W_ID(W_ID), .W_OPR(W_OPR), .W_FLAGS(W_FLAGS)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opr0_i(req_opr0), .req_opr1_i(req_opr1), .req_minus_i(req_minus),
`ifdef ADDX_ARB_LOCK_EN
    .req_lock_i(req_lock),
`endif
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_flags_o(rsp_flags)
  );

  // {overflow, sign, zero, carry, result} from plain signed/unsigned arithmetic
  function automatic logic [35:0] addx_ref(input logic [31:0] a, input logic [31:0] b, input bit minus);
    longint      sa = longint'($signed(a));
    longint      sb = longint'($signed(b));
    longint      lim = 64'sd2147483648;
    longint      sr;
    logic [32:0] u;
    logic [31:0] r;
    bit          c, v;
    if (minus) begin
      sr = sa - sb; r = a - b; c = (a >= b);
    end else begin
      sr = sa + sb; u = {1'b0, a} + {1'b0, b}; r = u[31:0]; c = u[32];
    end
    v = (sr >= lim) || (sr < -lim);
    return {v, r[31], (r == 32'd0), c, r};
  endfunction

  function automatic int exp_grant();
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (m_ptr + k) % N_REQ;
      if (req_valid[j] && (!m_lock || j == m_lock_id)) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int         g = exp_grant();
    logic [3:0] r = '0;
    if (!rst && g >= 0 && (!m_vld || rsp_ready)) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] rnd_opr();
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input bit m);
    req_opr0[k*32 +: 32] = a;
    req_opr1[k*32 +: 32] = b;
    req_minus[k]         = m;
  endtask

  task automatic rand_ops();
    for (int k = 0; k < N_REQ; k++) set_op(k, rnd_opr(), rnd_opr(), 1'($urandom_range(0, 1)));
  endtask

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_id = 0; m_res = '0; m_flags = '0; m_lock = 0; m_lock_id = 0;
  endtask

  // Advance the model with the current inputs, then move to 1 time unit after the next rising edge.
  task automatic tick();
    int         g;
    bit         can;
    logic [35:0] o;
    can = !m_vld || rsp_ready;
    g   = exp_grant();
    if (can && g >= 0) begin
      o = addx_ref(req_opr0[g*32 +: 32], req_opr1[g*32 +: 32], req_minus[g]);
      m_vld = 1; m_id = g; m_res = o[31:0]; m_flags = o[35:32];
`ifdef ADDX_ARB_LOCK_EN
      if (req_lock[g]) begin m_lock = 1; m_lock_id = g; end
      else begin m_lock = 0; m_ptr = (g + 1) % N_REQ; end
`else
      m_ptr = (g + 1) % N_REQ;
`endif
    end else begin
      if (can) m_vld = 0;
      if (m_lock && can && !req_valid[m_lock_id]) begin
        m_lock = 0; m_ptr = (m_lock_id + 1) % N_REQ;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL por_valid act=%0b exp=0", rsp_valid); else passes++;
    checks++; if (req_ready !== 4'b0) $display("FAIL por_ready act=%b exp=0000", req_ready); else passes++;
    rst = 1'b0; req_valid = '0; model_reset();
    // Park a result from req2 (pointer would move to 3) and stall it.
    set_op(2, rnd_opr(), rnd_opr(), 1'b0); req_valid = 4'b0100; rsp_ready = 1'b0; #1;
    checks++; if (req_ready !== exp_ready()) $display("FAIL rst_pre_ready act=%b exp=%b", req_ready, exp_ready()); else passes++;
    tick();
    req_valid = '0; tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL rst_stall_valid act=%0b exp=1", rsp_valid); else passes++;
    req_valid = '1; rst = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid act=%0b exp=0", rsp_valid); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL rst_id act=%0d exp=0", rsp_id); else passes++;
    checks++; if (rsp_result !== 32'd0) $display("FAIL rst_result act=%h exp=0", rsp_result); else passes++;
    checks++; if (rsp_flags !== 4'd0) $display("FAIL rst_flags act=%b exp=0000", rsp_flags); else passes++;
    checks++; if (req_ready !== 4'b0) $display("FAIL rst_ready act=%b exp=0000", req_ready); else passes++;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL rst_ptr act=%b exp=0001", req_ready); else passes++;
    tick();
    req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1; tick();
    set_op(0, 32'h7FFF_FFFF, 32'h1, 1'b0); req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) $display("FAIL single_ready act=%b exp=0001", req_ready); else passes++;
    tick();
    req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL single_valid act=%0b exp=1", rsp_valid); else passes++;
    checks++; if (rsp_id !== 2'd0) $display("FAIL single_id act=%0d exp=0", rsp_id); else passes++;
    checks++; if (rsp_result !== 32'h8000_0000) $display("FAIL single_result act=%h exp=80000000", rsp_result); else passes++;
    checks++; if (rsp_flags !== 4'b1100) $display("FAIL single_flags act=%b exp=1100", rsp_flags); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b0) $display("FAIL single_drain act=%0b exp=0", rsp_valid); else passes++;
  endtask

  task automatic test_subtract();
    set_op(2, 32'd5, 32'd5, 1'b1); req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) $display("FAIL sub_ready act=%b exp=0100", req_ready); else passes++;
    tick();
    req_valid = '0; #1;
    checks++; if (rsp_valid !== 1'b1) $display("FAIL sub_valid act=%0b exp=1", rsp_valid); else passes++;
    checks++; if (rsp_id !== 2'd2) $display("FAIL sub_id act=%0d exp=2", rsp_id); else passes++;
    checks++; if (rsp_result !== 32'd0) $display("FAIL sub_result act=%h exp=0", rsp_result); else passes++;
    checks++; if (rsp_flags !== 4'b0011) $display("FAIL sub_flags act=%b exp=0011", rsp_flags); else passes++;
    tick();
  endtask

  task automatic test_round_robin();
    int prev;
    rsp_ready = 1'b1; req_valid = '1;
    prev = -1;
    for (int c = 0; c < 12; c++) begin
      rand_ops(); #1;
      checks++; if (req_ready !== exp_ready()) $display("FAIL rr_ready cyc=%0d act=%b exp=%b", c, req_ready, exp_ready()); else passes++;
      tick();
      checks++; if (rsp_valid !== 1'b1) $display("FAIL rr_valid cyc=%0d act=%0b exp=1", c, rsp_valid); else passes++;
      checks++; if (rsp_id !== 2'(m_id)) $display("FAIL rr_id cyc=%0d act=%0d exp=%0d", c, rsp_id, m_id); else passes++;
      if (prev >= 0) begin
        checks++; if (rsp_id !== 2'((prev + 1) % N_REQ)) $display("FAIL rr_rotate cyc=%0d act=%0d exp=%0d", c, rsp_id, (prev + 1) % N_REQ); else passes++;
      end
      checks++; if ({rsp_flags, rsp_result} !== {m_flags, m_res}) $display("FAIL rr_data cyc=%0d act=%b/%h exp=%b/%h", c, rsp_flags, rsp_result, m_flags, m_res); else passes++;
      prev = m_id;
    end
    req_valid = '0; tick();
  endtask

  task automatic test_backpressure();
    rand_ops(); req_valid = 4'b1010; rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== exp_ready()) $display("FAIL bp_fill_ready act=%b exp=%b", req_ready, exp_ready()); else passes++;
    tick();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_ops(); #1;
      checks++; if (req_ready !== 4'b0) $display("FAIL bp_ready cyc=%0d act=%b exp=0000", c, req_ready); else passes++;
      checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid cyc=%0d act=%0b exp=1", c, rsp_valid); else passes++;
      checks++; if ({rsp_id, rsp_flags, rsp_result} !== {2'(m_id), m_flags, m_res})
        $display("FAIL bp_hold cyc=%0d act=%0d/%b/%h exp=%0d/%b/%h", c, rsp_id, rsp_flags, rsp_result, m_id, m_flags, m_res); else passes++;
      tick();
    end
    rsp_ready = 1'b1; #1;
    checks++; if (req_ready !== exp_ready() || req_ready === 4'b0) $display("FAIL bp_refill_ready act=%b exp=%b", req_ready, exp_ready()); else passes++;
    tick();
    checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_nobubble act=%0b exp=1", rsp_valid); else passes++;
    checks++; if ({rsp_id, rsp_flags, rsp_result} !== {2'(m_id), m_flags, m_res})
      $display("FAIL bp_refill act=%0d/%b/%h exp=%0d/%b/%h", rsp_id, rsp_flags, rsp_result, m_id, m_flags, m_res); else passes++;
    req_valid = '0; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rand_ops();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ADDX_ARB_LOCK_EN
      req_lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
`endif
      #1;
      checks++; if (req_ready !== exp_ready()) $display("FAIL rnd_ready cyc=%0d act=%b exp=%b", c, req_ready, exp_ready()); else passes++;
      checks++; if (rsp_valid !== m_vld) $display("FAIL rnd_valid cyc=%0d act=%0b exp=%0b", c, rsp_valid, m_vld); else passes++;
      if (m_vld) begin
        checks++; if ({rsp_id, rsp_flags, rsp_result} !== {2'(m_id), m_flags, m_res})
          $display("FAIL rnd_data cyc=%0d act=%0d/%b/%h exp=%0d/%b/%h", c, rsp_id, rsp_flags, rsp_result, m_id, m_flags, m_res); else passes++;
      end
      tick();
    end
`ifdef ADDX_ARB_LOCK_EN
    req_lock = '0;
`endif
    req_valid = '0; rsp_ready = 1'b1; tick();
  endtask

`ifdef ADDX_ARB_LOCK_EN
  task automatic test_lock();
    int exp_ids [4] = '{1, 1, 1, 0};
    rst = 1'b1; #1; model_reset();
    @(posedge clk); #1;
    rst = 1'b0; rsp_ready = 1'b1;
    set_op(0, rnd_opr(), rnd_opr(), 1'b0); req_valid = 4'b0001; tick();
    req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      rand_ops();
      req_lock = (i < 2) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (req_ready !== (4'b0001 << exp_ids[i])) $display("FAIL lock_ready op=%0d act=%b exp_id=%0d", i, req_ready, exp_ids[i]); else passes++;
      tick();
      checks++; if (rsp_id !== 2'(exp_ids[i])) $display("FAIL lock_id op=%0d act=%0d exp=%0d", i, rsp_id, exp_ids[i]); else passes++;
      checks++; if ({rsp_flags, rsp_result} !== {m_flags, m_res}) $display("FAIL lock_data op=%0d act=%b/%h exp=%b/%h", i, rsp_flags, rsp_result, m_flags, m_res); else passes++;
    end
    req_lock = '0; req_valid = '0; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_subtract();
    test_round_robin();
    test_backpressure();
    test_random();
`ifdef ADDX_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
